// File: rtl/div_mod_sequencer_if.sv
// Operand/result bundle between the pipeline and the divide/modulo sequencer.
// The pipeline drives the master side; the sequencer is the slave.
interface div_mod_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;

  modport master (
    output en, ALUControl, SrcA, SrcB,
    input  stall, busy, done, result, div_by_zero
  );

  modport slave (
    input  en, ALUControl, SrcA, SrcB,
    output stall, busy, done, result, div_by_zero
  );
endinterface

// File: rtl/div_mod_sequencer.sv
// Restoring shift-subtract unsigned divider, one quotient bit per cycle.
// It stalls the pipeline while running and pulses done with the quotient or remainder.
module div_mod_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  div_mod_sequencer_if.slave  bus
);
  localparam int         CNT_W  = $clog2(WIDTH);
  localparam logic [3:0] OP_DIV = 4'b1000;
  localparam logic [3:0] OP_MOD = 4'b0100;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic             op_mod_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] result_q;
  logic             dbz_q;

  logic             start;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;

  assign start = bus.en & ((bus.ALUControl == OP_DIV) | (bus.ALUControl == OP_MOD));

  // rem < divisor always holds, so WIDTH bits suffice for it; the extra bit of
  // the shifted value is the borrow detector.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rem_d     = rem_q;
    quo_d     = quo_q;
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, dvs_q};
    if (!diff[WIDTH]) begin
      rem_d = diff[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = rem_shift[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_mod_q <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_mod_q <= (bus.ALUControl == OP_MOD);
            quo_q    <= bus.SrcA;
            rem_q    <= '0;
            dvs_q    <= bus.SrcB;
            count_q  <= CNT_W'(WIDTH - 1);
            if (bus.SrcB == '0) begin
              result_q <= (bus.ALUControl == OP_MOD) ? bus.SrcA : '1;
              dbz_q    <= 1'b1;
              state_q  <= DONE;
            end else begin
              state_q  <= RUN;
            end
          end
        end
        RUN: begin
          rem_q   <= rem_d;
          quo_q   <= quo_d;
          count_q <= count_q - CNT_W'(1);
          // The last iteration's values go straight into the result register.
          if (count_q == '0) begin
            result_q <= op_mod_q ? rem_d : quo_d;
            dbz_q    <= 1'b0;
            state_q  <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stall is gated by reset so an abort releases the pipeline at once.
  assign bus.stall       = ~reset & (((state_q == IDLE) & start) | (state_q == RUN));
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;
endmodule
